// File: rtl/ctrl_pkg.sv
// Shared encodings for the accumulator processor control unit and its datapath muxes.
package ctrl_pkg;

  // Opcode field IR[15:12]
  localparam logic [3:0] OpAddi = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpLw   = 4'h5;
  localparam logic [3:0] OpSw   = 4'h6;
  localparam logic [3:0] OpLi   = 4'h7;
  localparam logic [3:0] OpBeq  = 4'h8;
  localparam logic [3:0] OpBne  = 4'h9;
  localparam logic [3:0] OpJ    = 4'hA;
  localparam logic [3:0] OpJal  = 4'hB;
  localparam logic [3:0] OpRet  = 4'hC;
  localparam logic [3:0] OpIn   = 4'hD;
  localparam logic [3:0] OpOut  = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecI  = 4'd2,
    StMemRd  = 4'd3,
    StExecM  = 4'd4,
    StWb     = 4'd5,
    StMemWr  = 4'd6,
    StBranch = 4'd7,
    StJump   = 4'd8,
    StPush   = 4'd9,
    StPopInc = 4'd10,
    StPopRd  = 4'd11,
    StRetPc  = 4'd12,
    StOutW   = 4'd13,
    StHalt   = 4'd14
  } state_e;

  localparam logic [1:0] IordPc     = 2'b00;
  localparam logic [1:0] IordImm    = 2'b01;
  localparam logic [1:0] IordAluOut = 2'b10;
  localparam logic [1:0] IordSp     = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcImm    = 2'b10;
  localparam logic [1:0] PcSrcMdr    = 2'b11;

  localparam logic [1:0] AccSrcAluOut = 2'b00;
  localparam logic [1:0] AccSrcMdr    = 2'b01;
  localparam logic [1:0] AccSrcImm    = 2'b10;
  localparam logic [1:0] AccSrcIn     = 2'b11;

  localparam logic [1:0] AluBOne = 2'b00;
  localparam logic [1:0] AluBImm = 2'b01;
  localparam logic [1:0] AluBMdr = 2'b10;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;

  localparam logic [1:0] BrNone = 2'b00;
  localparam logic [1:0] BrEq   = 2'b01;
  localparam logic [1:0] BrNe   = 2'b10;

  localparam logic [1:0] DataSrcPc  = 2'b00;
  localparam logic [1:0] DataSrcAcc = 2'b01;

  // Non-ALU control outputs, registered as one bundle
  typedef struct packed {
    logic       pc_write;
    logic       jump;
    logic [1:0] branch;
    logic [1:0] pc_src;
    logic [1:0] iord;
    logic [1:0] data_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       acc_write;
    logic [1:0] acc_src;
    logic       sp_write;
    logic       sp_dec;
    logic       out_write;
    logic       halted;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// ALU operation and operand-select decode for a given control state and opcode.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  state_e     state,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b
);

  // Per-state ALU setup; EXEC_M takes its operation from the opcode
  always_comb begin
    alu_op    = AluAdd;
    alu_src_a = 1'b0;
    alu_src_b = AluBOne;
    unique case (state)
      StDecode: alu_src_b = AluBImm;
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = AluBImm;
      end
      StExecM: begin
        alu_src_a = 1'b1;
        alu_src_b = AluBMdr;
        unique case (opcode)
          OpSub:   alu_op = AluSub;
          OpAnd:   alu_op = AluAnd;
          OpOr:    alu_op = AluOr;
          default: alu_op = AluAdd;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit for the 16-bit accumulator processor.
// Define CTRL_STACK_OPS_EN to build JAL/RET; otherwise opcodes B and C decode as illegal.
// All outputs are registered; they are computed from the next state so they line up with State.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  output logic       PCWrite,
  output logic       Jump,
  output logic [1:0] Branch,
  output logic [1:0] PCSrc,
  output logic [1:0] IorD,
  output logic [1:0] DataSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AccWrite,
  output logic [1:0] AccSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       SPWrite,
  output logic       SPDec,
  output logic       OutWrite,
  output logic       Halted,
  output logic       IllegalOp,
  output logic [3:0] State
);

`ifdef CTRL_STACK_OPS_EN
  localparam bit StackEn = 1'b1;
`else
  localparam bit StackEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic       run_q;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] alu_op_d, alu_op_q;
  logic       alu_src_a_d, alu_src_a_q;
  logic [1:0] alu_src_b_d, alu_src_b_q;
  logic       op_illegal;

  assign op_illegal = !StackEn && ((Opcode == OpJal) || (Opcode == OpRet));

  alu_op_decode u_alu_op_decode (
    .opcode    (Opcode),
    .state     (state_d),
    .alu_op    (alu_op_d),
    .alu_src_a (alu_src_a_d),
    .alu_src_b (alu_src_b_d)
  );

  // Next-state sequencing; the first cycle after reset release is spent in FETCH
  always_comb begin
    state_d = state_q;
    if (!run_q) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StFetch: state_d = StDecode;
        StDecode: begin
          unique case (Opcode)
            OpAddi:                           state_d = StExecI;
            OpAdd, OpSub, OpAnd, OpOr, OpLw:  state_d = StMemRd;
            OpSw:                             state_d = StMemWr;
            OpLi, OpIn:                       state_d = StWb;
            OpBeq, OpBne:                     state_d = StBranch;
            OpJ:                              state_d = StJump;
`ifdef CTRL_STACK_OPS_EN
            OpJal:                            state_d = StPush;
            OpRet:                            state_d = StPopInc;
`endif
            OpOut:                            state_d = StOutW;
            OpHalt:                           state_d = StHalt;
            default:                          state_d = StFetch;
          endcase
        end
        StExecI:  state_d = StWb;
        StMemRd:  state_d = (Opcode == OpLw) ? StWb : StExecM;
        StExecM:  state_d = StWb;
        StHalt:   state_d = StHalt;
`ifdef CTRL_STACK_OPS_EN
        StPush:   state_d = StJump;
        StPopInc: state_d = StPopRd;
        StPopRd:  state_d = StRetPc;
`endif
        default:  state_d = StFetch;
      endcase
    end
  end

  // Output bundle for the state being entered
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      StFetch: begin
        ctrl_d.iord     = IordPc;
        ctrl_d.mem_read = 1'b1;
        ctrl_d.ir_write = 1'b1;
        ctrl_d.pc_write = 1'b1;
        ctrl_d.pc_src   = PcSrcAlu;
      end
      StDecode: ctrl_d.illegal_op = op_illegal;
      StMemRd: begin
        ctrl_d.iord     = IordImm;
        ctrl_d.mem_read = 1'b1;
      end
      StWb: begin
        ctrl_d.acc_write = 1'b1;
        unique case (Opcode)
          OpLw:    ctrl_d.acc_src = AccSrcMdr;
          OpLi:    ctrl_d.acc_src = AccSrcImm;
          OpIn:    ctrl_d.acc_src = AccSrcIn;
          default: ctrl_d.acc_src = AccSrcAluOut;
        endcase
      end
      StMemWr: begin
        ctrl_d.iord      = IordImm;
        ctrl_d.data_src  = DataSrcAcc;
        ctrl_d.mem_write = 1'b1;
      end
      StBranch: begin
        ctrl_d.branch = (Opcode == OpBne) ? BrNe : BrEq;
        ctrl_d.pc_src = PcSrcAluOut;
      end
      StJump: begin
        ctrl_d.jump   = 1'b1;
        ctrl_d.pc_src = PcSrcImm;
      end
`ifdef CTRL_STACK_OPS_EN
      StPush: begin
        // Stores PC+1 at SP, then post-decrements (empty-descending stack)
        ctrl_d.iord      = IordSp;
        ctrl_d.data_src  = DataSrcPc;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.sp_write  = 1'b1;
        ctrl_d.sp_dec    = 1'b1;
      end
      StPopInc: ctrl_d.sp_write = 1'b1;
      StPopRd: begin
        ctrl_d.iord     = IordSp;
        ctrl_d.mem_read = 1'b1;
      end
      StRetPc: begin
        ctrl_d.jump   = 1'b1;
        ctrl_d.pc_src = PcSrcMdr;
      end
`endif
      StOutW:  ctrl_d.out_write = 1'b1;
      StHalt:  ctrl_d.halted    = 1'b1;
      default: ;
    endcase
  end

  // State and registered outputs; async reset drops every strobe at once
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StFetch;
      run_q       <= 1'b0;
      ctrl_q      <= '0;
      alu_op_q    <= AluAdd;
      alu_src_a_q <= 1'b0;
      alu_src_b_q <= AluBOne;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      ctrl_q      <= ctrl_d;
      alu_op_q    <= alu_op_d;
      alu_src_a_q <= alu_src_a_d;
      alu_src_b_q <= alu_src_b_d;
    end
  end

  assign PCWrite   = ctrl_q.pc_write;
  assign Jump      = ctrl_q.jump;
  assign Branch    = ctrl_q.branch;
  assign PCSrc     = ctrl_q.pc_src;
  assign IorD      = ctrl_q.iord;
  assign DataSrc   = ctrl_q.data_src;
  assign MemRead   = ctrl_q.mem_read;
  assign MemWrite  = ctrl_q.mem_write;
  assign IRWrite   = ctrl_q.ir_write;
  assign AccWrite  = ctrl_q.acc_write;
  assign AccSrc    = ctrl_q.acc_src;
  assign ALUSrcA   = alu_src_a_q;
  assign ALUSrcB   = alu_src_b_q;
  assign ALUOp     = alu_op_q;
  assign SPWrite   = ctrl_q.sp_write & StackEn;
  assign SPDec     = ctrl_q.sp_dec & StackEn;
  assign OutWrite  = ctrl_q.out_write;
  assign Halted    = ctrl_q.halted;
  assign IllegalOp = ctrl_q.illegal_op;
  assign State     = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle expected output vectors are queued per instruction
// and compared one per clock against the DUT.
module tb_control_fsm;
  import ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] Opcode;
  logic       PCWrite, Jump, MemRead, MemWrite, IRWrite, AccWrite, ALUSrcA;
  logic       SPWrite, SPDec, OutWrite, Halted, IllegalOp;
  logic [1:0] Branch, PCSrc, IorD, DataSrc, AccSrc, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] State;

  always #5 CLK = ~CLK;

  control_fsm dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Opcode    (Opcode),
    .PCWrite   (PCWrite),
    .Jump      (Jump),
    .Branch    (Branch),
    .PCSrc     (PCSrc),
    .IorD      (IorD),
    .DataSrc   (DataSrc),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .AccWrite  (AccWrite),
    .AccSrc    (AccSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .SPWrite   (SPWrite),
    .SPDec     (SPDec),
    .OutWrite  (OutWrite),
    .Halted    (Halted),
    .IllegalOp (IllegalOp),
    .State     (State)
  );

  logic [31:0] obs;
  assign obs = {PCWrite, Jump, Branch, PCSrc, IorD, DataSrc, MemRead, MemWrite, IRWrite,
                AccWrite, AccSrc, ALUSrcA, ALUSrcB, ALUOp, SPWrite, SPDec, OutWrite, Halted,
                IllegalOp, State};

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] vec;
  } exp_t;
  exp_t sb_q[$];

  // Expected outputs for one cycle in state st with opcode op, straight from the state table
  function automatic logic [31:0] model(state_e st, logic [3:0] op);
    logic       pcw, jmp, mr, mw, irw, aw, sa, spw, spd, ow, h, ill;
    logic [1:0] br, pcs, iord, ds, as, sb;
    logic [2:0] aop;
    pcw = 0; jmp = 0; mr = 0; mw = 0; irw = 0; aw = 0; sa = 0;
    spw = 0; spd = 0; ow = 0; h = 0; ill = 0;
    br = 0; pcs = 0; iord = 0; ds = 0; as = 0; sb = 0; aop = 0;
    case (st)
      StFetch:  begin mr = 1; irw = 1; pcw = 1; end
      StDecode: begin
        sb = 2'b01;
`ifndef CTRL_STACK_OPS_EN
        ill = (op == 4'hB) || (op == 4'hC);
`endif
      end
      StExecI:  begin sa = 1; sb = 2'b01; end
      StMemRd:  begin iord = 2'b01; mr = 1; end
      StExecM:  begin
        sa = 1; sb = 2'b10;
        aop = (op == 4'h2) ? 3'd1 : (op == 4'h3) ? 3'd2 : (op == 4'h4) ? 3'd3 : 3'd0;
      end
      StWb:     begin
        aw = 1;
        as = (op == 4'h5) ? 2'b01 : (op == 4'h7) ? 2'b10 : (op == 4'hD) ? 2'b11 : 2'b00;
      end
      StMemWr:  begin iord = 2'b01; ds = 2'b01; mw = 1; end
      StBranch: begin br = (op == 4'h9) ? 2'b10 : 2'b01; pcs = 2'b01; end
      StJump:   begin jmp = 1; pcs = 2'b10; end
      StPush:   begin iord = 2'b11; mw = 1; spw = 1; spd = 1; end
      StPopInc: spw = 1;
      StPopRd:  begin iord = 2'b11; mr = 1; end
      StRetPc:  begin jmp = 1; pcs = 2'b11; end
      StOutW:   ow = 1;
      StHalt:   h = 1;
      default:  ;
    endcase
    return {pcw, jmp, br, pcs, iord, ds, mr, mw, irw, aw, as, sa, sb, aop, spw, spd, ow, h,
            ill, st};
  endfunction

  task automatic push_state(string name, state_e st, logic [3:0] op);
    exp_t e;
    e.tag = $sformatf("%s@%s", name, st.name());
    e.vec = model(st, op);
    sb_q.push_back(e);
  endtask

  // Queue the full state sequence one instruction should walk through
  task automatic push_instr(string name, logic [3:0] op);
    push_state(name, StFetch, op);
    push_state(name, StDecode, op);
    case (op)
      4'h0: begin push_state(name, StExecI, op); push_state(name, StWb, op); end
      4'h1, 4'h2, 4'h3, 4'h4: begin
        push_state(name, StMemRd, op);
        push_state(name, StExecM, op);
        push_state(name, StWb, op);
      end
      4'h5: begin push_state(name, StMemRd, op); push_state(name, StWb, op); end
      4'h6: push_state(name, StMemWr, op);
      4'h7, 4'hD: push_state(name, StWb, op);
      4'h8, 4'h9: push_state(name, StBranch, op);
      4'hA: push_state(name, StJump, op);
`ifdef CTRL_STACK_OPS_EN
      4'hB: begin push_state(name, StPush, op); push_state(name, StJump, op); end
      4'hC: begin
        push_state(name, StPopInc, op);
        push_state(name, StPopRd, op);
        push_state(name, StRetPc, op);
      end
`endif
      4'hE: push_state(name, StOutW, op);
      4'hF: push_state(name, StHalt, op);
      default: ;
    endcase
  endtask

  task automatic check(string tag, logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Compare one queued entry per cycle; called #1 after the edge that shows the first entry
  task automatic drain(bit advance_last);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, e.vec);
      if (sb_q.size() > 0 || advance_last) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic run(string name, logic [3:0] op);
    Opcode = op;
    push_instr(name, op);
    drain(1'b1);
  endtask

  initial begin
    Opcode = 4'h0;
    Reset  = 1'b1;
    #1 Reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check("reset_state", 32'h0);
    @(negedge CLK) Reset = 1'b1;
    @(posedge CLK);
    #1;

    run("addi", 4'h0);
    run("sub",  4'h2);
    run("bne",  4'h9);
    run("lw",   4'h5);
    run("sw",   4'h6);
    run("li",   4'h7);
    run("add",  4'h1);
    run("and",  4'h3);
    run("or",   4'h4);
    run("beq",  4'h8);
    run("j",    4'hA);
    run("in",   4'hD);
    run("out",  4'hE);
    run("jal",  4'hB);
    run("ret",  4'hC);

    // Reset in the middle of EXEC_M: strobes clear before the next edge
    Opcode = 4'h2;
    push_state("sub_rst", StFetch, 4'h2);
    push_state("sub_rst", StDecode, 4'h2);
    push_state("sub_rst", StMemRd, 4'h2);
    drain(1'b1);
    push_state("sub_rst", StExecM, 4'h2);
    drain(1'b0);
    #2 Reset = 1'b0;
    #1 check("reset_async_clear", 32'h0);
    @(posedge CLK);
    #1 check("reset_held", 32'h0);
    @(negedge CLK) Reset = 1'b1;
    @(posedge CLK);
    #1;
    run("or_after_rst", 4'h4);

    // HALT is sticky for 20 further cycles with no strobes
    Opcode = 4'hF;
    push_instr("halt", 4'hF);
    for (int i = 0; i < 20; i++) push_state("halt_hold", StHalt, 4'hF);
    Opcode = 4'hF;
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the 16-bit accumulator processor. It sits directly downstream of the fetch/memory stage and consumes the opcode field of the instruction register that stage produces. Each cycle it drives that stage's control inputs (PCWrite, Jump, Branch, IorD, DataSrc, MemRead, MemWrite, IRWrite) and the execute-side controls for the accumulator, ALU, SP and output port. It sequences every instruction through a fixed state machine.

## Interface
- No parameters; all encodings are constants in the shared package.
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low; 0 forces state FETCH and clears all flags.
- Opcode  in  4  IR[15:12]; valid from the DECODE cycle onward.
- PCWrite, Jump  out  1  unconditional PC write strobes.
- Branch  out  2  00 none, 01 BEQ, 10 BNE; the fetch stage qualifies it with ShouldBranch.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 Imm, 11 MDR.
- IorD  out  2  00 PC, 01 Imm, 10 ALUOut, 11 SP.
- DataSrc  out  2  00 PC, 01 Acc.
- MemRead, MemWrite, IRWrite  out  1  memory and IR strobes.
- AccWrite  out  1  accumulator load.
- AccSrc  out  2  00 ALUOut, 01 MDR, 10 Imm, 11 Inputio.
- ALUSrcA  out  1  0 PC, 1 Acc.
- ALUSrcB  out  2  00 constant 1, 01 Imm, 10 MDR.
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or.
- SPWrite, SPDec  out  1  SP update; SPDec=1 decrements, 0 increments.
- OutWrite  out  1  output-port load.
- Halted  out  1  sticky flag, high in HALT.
- IllegalOp  out  1  one-cycle pulse when an undefined opcode is decoded.
- State  out  4  current state, for debug.

## Operation
- Outputs are Moore-style. Every strobe defaults to 0 and every select to 00 unless listed below.
- Opcodes: 0 ADDI, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LW, 6 SW, 7 LI, 8 BEQ, 9 BNE, A J, B JAL, C RET, D IN, E OUT, F HALT.
- In the operand opcodes 1–4, the Imm field is the address of the memory operand.
- FETCH: IorD=00, MemRead, IRWrite, ALUSrcA=0, ALUSrcB=00, add, PCWrite, PCSrc=00 → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=01, add. This precomputes the branch target (PC+1)+Imm into ALUOut. Dispatch by opcode:
  - 0 → EXEC_I
  - 1–5 → MEM_RD
  - 6 → MEM_WR
  - 7, D → WB
  - 8, 9 → BRANCH
  - A → JUMP
  - B → PUSH
  - C → POP_INC
  - E → OUT_W
  - F → HALT
- EXEC_I: ALUSrcA=1, ALUSrcB=01, add → WB.
- MEM_RD: IorD=01, MemRead. Opcode 5 → WB; opcodes 1–4 → EXEC_M.
- EXEC_M: ALUSrcA=1, ALUSrcB=10, ALUOp = opcode−1 → WB.
- WB: AccWrite. AccSrc is 00 for ALU ops, 01 for LW, 10 for LI, 11 for IN. → FETCH.
- MEM_WR: IorD=01, DataSrc=01, MemWrite → FETCH.
- BRANCH: Branch=01 (op 8) or 10 (op 9), PCSrc=01 → FETCH.
- JUMP: Jump, PCSrc=10 → FETCH.
- PUSH: IorD=11, DataSrc=00, MemWrite, SPWrite, SPDec=1 → JUMP. This stores PC+1; SP is empty-descending.
- POP_INC: SPWrite, SPDec=0 → POP_RD.
- POP_RD: IorD=11, MemRead → RET_PC.
- RET_PC: Jump, PCSrc=11 → FETCH.
- OUT_W: OutWrite → FETCH.
- HALT: Halted=1. Stays in HALT until Reset.

## Timing
- Reset values:
  - state FETCH
  - every strobe and select 0
  - Halted=0, IllegalOp=0, State=0
- FETCH outputs are asserted in the first cycle after Reset deasserts.
- The IR captures on the falling edge within FETCH, so Opcode is stable for the whole of DECODE.
- Memory reads are synchronous: MDR data is usable in the cycle after MemRead.
- Cycles per instruction:
  - ADDI 4; ADD/SUB/AND/OR 5
  - LW 4; SW 3; LI 3
  - branch 3; J 3; JAL 4; RET 5
  - IN 3; OUT 3
- Reset asserted mid-instruction: all strobes drop immediately (asynchronously) and no partial write completes after release.

## Configuration
- CTRL_STACK_OPS_EN defined: JAL and RET behave as above.
- CTRL_STACK_OPS_EN undefined:
  - opcodes B and C are illegal: DECODE pulses IllegalOp for one cycle, then → FETCH
  - PUSH, POP_INC, POP_RD and RET_PC are not built
  - SPWrite and SPDec are tied to 0

## Structure
- ctrl_pkg holds:
  - opcode constants
  - state encodings
  - IorD, PCSrc, AccSrc, ALUSrcB and ALUOp codes
- Both this block and the datapath muxes use ctrl_pkg.
- One sub-module: alu_op_decode, combinational, mapping opcode and state to ALUOp, ALUSrcA and ALUSrcB.

## Test plan
- Reset low for 3 cycles, then high: State=FETCH; first cycle has MemRead=1, IRWrite=1, PCWrite=1, IorD=00; every other output 0.
- Opcode 0 (ADDI): states F, D, EXEC_I, WB; AccWrite=1 with AccSrc=00 only in cycle 4; back in FETCH at cycle 5.
- Opcode 2 (SUB): MEM_RD has IorD=01 and MemRead=1; EXEC_M has ALUOp=001 and ALUSrcB=10; total 5 cycles.
- Opcode 9 (BNE): BRANCH cycle shows Branch=10, PCSrc=01, PCWrite=0, Jump=0.
- Opcode B, then C, with the macro defined:
  - PUSH: IorD=11, MemWrite=1, SPDec=1
  - then JUMP: Jump=1, PCSrc=10
  - RET: POP_INC (SPDec=0), then POP_RD, then RET_PC (PCSrc=11)
  - without the macro: one-cycle IllegalOp pulse, then FETCH
- Opcode F: Halted=1 and held for 20 cycles with no strobes. Reset pulsed low in the middle of an EXEC_M cycle: outputs clear at once, and FETCH resumes after release.
